stream_mux_nto1: RTL and testbench

- Parametrised, registered N-to-1 multiplexer carrying W-bit data with valid/ready handshakes on every input and on the output.
- Two selection modes: a fixed mode, where an external select picks the channel as the combinational 4-to-1 muxes do, and a round-robin mode with fair arbitration.
- A single output register decouples the source from the consumer.
- Sits between channel producers (e.g. per-lane registers) and a single downstream consumer.

---
 rtl/stream_mux_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/stream_mux_nto1.sv | 93 +++++++++
 tb/tb_stream_mux_nto1.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-to-1 stream multiplexer.
// Holds the mode encodings, output-register states and a modulo increment.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } oreg_state_t;

    // Next index in a ring of n channels.
    function automatic int mod_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping.
// Ports: req (N requests), ptr (last winner), gnt (index), gnt_valid.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt,
    output logic             gnt_valid
);

    logic [SEL_W-1:0] w_idx;

    // Visit ptr+1 .. ptr+N; the first hit keeps the grant.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        w_idx     = ptr;
        for (int k = 0; k < N; k++) begin
            w_idx = SEL_W'(mod_inc(int'(w_idx), N));
            if (!gnt_valid && req[w_idx]) begin
                gnt       = w_idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 stream mux, fixed-select or round-robin arbitration.
// Ports: clk, rst (sync, high), mode, sel, in_data/in_valid/in_ready,
//        out_data/out_chan/out_valid/out_ready.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    oreg_state_t      r_state;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_chan;
    logic [SEL_W-1:0] r_ptr;

    logic [SEL_W-1:0] w_rr_gnt;
    logic             w_rr_valid;
    logic             w_fix_valid;
    logic [SEL_W-1:0] w_gnt;
    logic             w_gnt_valid;
    logic             w_load_en;
    logic             w_take;
    logic [WIDTH-1:0] w_gnt_data;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .gnt       (w_rr_gnt),
        .gnt_valid (w_rr_valid)
    );

    // Out-of-range select never grants.
    always_comb begin
        w_fix_valid = 1'b0;
        if (int'(sel) < N) begin
            w_fix_valid = in_valid[sel];
        end
    end

    assign w_gnt       = (mode == MODE_RR) ? w_rr_gnt : sel;
    assign w_gnt_valid = (mode == MODE_RR) ? w_rr_valid : w_fix_valid;

    assign out_valid  = (r_state == ST_FULL);
    assign w_load_en  = !out_valid || out_ready;
    // A grant implies in_valid, so ready alone marks the handshake.
    assign w_take     = w_load_en && w_gnt_valid && !rst;
    assign w_gnt_data = in_data[int'(w_gnt)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (w_take) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_chan  <= '0;
            r_ptr   <= SEL_W'(N - 1);
        end else if (w_take) begin
            r_state <= ST_FULL;
            r_data  <= w_gnt_data;
            r_chan  <= w_gnt;
            if (mode == MODE_RR) begin
                r_ptr <= w_gnt;
            end
        end else if (out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_data = r_data;
    assign out_chan = r_chan;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: directed vector table plus random traffic
// checked against a ring-scan reference model.
module tb_stream_mux_nto1;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic                 clk;
    logic                 rst;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_chan;
    logic                 out_valid;
    logic                 out_ready;

    int n_checks;
    int n_fail;

    stream_mux_nto1 #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       rst;
        bit       mode;
        bit [1:0] sel;
        bit [3:0] vld;
        bit       ordy;
        bit [3:0] e_rdy;
        bit       c_ov;
        bit       e_ov;
        bit       c_dc;
        bit [7:0] e_data;
        bit [1:0] e_chan;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic add(input bit r, input bit m, input int s,
                       input int v, input bit o, input int er,
                       input bit cov, input bit eov, input bit cdc,
                       input int ed, input int ec);
        vec_t t;
        t.rst = r; t.mode = m; t.sel = 2'(s); t.vld = 4'(v);
        t.ordy = o; t.e_rdy = 4'(er); t.c_ov = cov; t.e_ov = eov;
        t.c_dc = cdc; t.e_data = 8'(ed); t.e_chan = 2'(ec);
        tv.push_back(t);
    endtask

    // Reference: grant index from the spec's selection rules.
    function automatic int ref_grant(input bit m, input int s,
                                     input bit [3:0] v, input int p);
        if (m == 1'b0) begin
            if (s < N && v[s]) return s;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    bit       m_valid;
    bit       m_known;
    int       m_data;
    int       m_chan;
    int       m_ptr;

    // One cycle: drive, settle, compare, then step the model over the edge.
    task automatic rnd_cycle(input bit r, input bit m, input int s,
                             input bit [3:0] v, input bit o,
                             input bit [31:0] d);
        int g;
        int er;
        rst = r; mode = m; sel = 2'(s); in_valid = v;
        out_ready = o; in_data = d;
        #3;
        g  = ref_grant(m, s, v, m_ptr);
        er = 0;
        if (!r && (!m_valid || o) && g >= 0) er = 1 << g;
        chk("rnd_in_ready", int'(in_ready), er);
        if (m_known) chk("rnd_out_valid", int'(out_valid), int'(m_valid));
        if (m_known && m_valid) begin
            chk("rnd_out_data", int'(out_data), m_data);
            chk("rnd_out_chan", int'(out_chan), m_chan);
        end
        if (r) begin
            m_valid = 0; m_data = 0; m_chan = 0;
            m_ptr = N - 1; m_known = 1;
        end else if (er != 0) begin
            m_valid = 1;
            m_data  = int'((d >> (g * WIDTH)) & 32'hFF);
            m_chan  = g;
            if (m) m_ptr = g;
        end else if (o) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit       rm;
        bit [3:0] rv;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0;
        out_ready = 1'b0; in_data = 32'hDDCCBBAA;

        // rst m  sel vld  ordy rdy  cov eov cdc data  chan
        add(1, 1, 0, 4'hF, 1, 4'h0, 0, 0, 0, 8'h00, 0);
        add(1, 1, 0, 4'hF, 1, 4'h0, 1, 0, 1, 8'h00, 0);
        add(0, 1, 0, 4'hF, 1, 4'h1, 1, 0, 1, 8'h00, 0);
        add(0, 0, 2, 4'hF, 1, 4'h4, 1, 1, 1, 8'hAA, 0);
        add(0, 0, 2, 4'hF, 1, 4'h4, 1, 1, 1, 8'hCC, 2);
        add(0, 0, 2, 4'hF, 1, 4'h4, 1, 1, 1, 8'hCC, 2);
        add(0, 0, 3, 4'h7, 1, 4'h0, 1, 1, 1, 8'hCC, 2);
        add(0, 0, 3, 4'h7, 1, 4'h0, 1, 0, 0, 8'h00, 0);
        add(1, 1, 0, 4'hF, 1, 4'h0, 1, 0, 0, 8'h00, 0);
        add(0, 1, 0, 4'hF, 1, 4'h1, 1, 0, 1, 8'h00, 0);
        add(0, 1, 0, 4'hF, 1, 4'h2, 1, 1, 1, 8'hAA, 0);
        add(0, 1, 0, 4'hF, 1, 4'h4, 1, 1, 1, 8'hBB, 1);
        add(0, 1, 0, 4'hF, 1, 4'h8, 1, 1, 1, 8'hCC, 2);
        add(0, 1, 0, 4'hF, 1, 4'h1, 1, 1, 1, 8'hDD, 3);
        add(0, 1, 0, 4'hF, 1, 4'h2, 1, 1, 1, 8'hAA, 0);
        add(0, 1, 0, 4'hF, 1, 4'h4, 1, 1, 1, 8'hBB, 1);
        add(0, 1, 0, 4'hF, 1, 4'h8, 1, 1, 1, 8'hCC, 2);
        add(0, 1, 0, 4'hA, 1, 4'h2, 1, 1, 1, 8'hDD, 3);
        add(0, 1, 0, 4'hA, 1, 4'h8, 1, 1, 1, 8'hBB, 1);
        add(0, 1, 0, 4'hA, 1, 4'h2, 1, 1, 1, 8'hDD, 3);
        add(0, 1, 0, 4'hA, 1, 4'h8, 1, 1, 1, 8'hBB, 1);
        add(0, 1, 0, 4'h2, 1, 4'h2, 1, 1, 1, 8'hDD, 3);
        add(0, 1, 0, 4'h2, 1, 4'h2, 1, 1, 1, 8'hBB, 1);
        add(0, 1, 0, 4'h2, 1, 4'h2, 1, 1, 1, 8'hBB, 1);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 4'hF, 0, 4'h0, 1, 1, 1, 8'hBB, 1);
        add(0, 1, 0, 4'hF, 1, 4'h4, 1, 1, 1, 8'hBB, 1);
        add(0, 1, 0, 4'hF, 0, 4'h0, 1, 1, 1, 8'hCC, 2);
        add(1, 1, 0, 4'hF, 0, 4'h0, 1, 1, 1, 8'hCC, 2);
        add(0, 1, 0, 4'h6, 0, 4'h2, 1, 0, 1, 8'h00, 0);
        add(0, 1, 0, 4'h6, 1, 4'h4, 1, 1, 1, 8'hBB, 1);
        add(0, 1, 0, 4'h0, 1, 4'h0, 1, 1, 1, 8'hCC, 2);
        add(0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 0, 8'h00, 0);
        add(0, 0, 0, 4'h1, 1, 4'h1, 1, 0, 0, 8'h00, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 1, 1, 1, 8'hAA, 0);
        add(0, 0, 3, 4'h8, 0, 4'h0, 1, 1, 1, 8'hAA, 0);
        add(0, 1, 0, 4'hF, 1, 4'h8, 1, 1, 1, 8'hAA, 0);

        foreach (tv[i]) begin
            rst = tv[i].rst; mode = tv[i].mode; sel = tv[i].sel;
            in_valid = tv[i].vld; out_ready = tv[i].ordy;
            #3;
            chk($sformatf("v%0d_in_ready", i),
                int'(in_ready), int'(tv[i].e_rdy));
            if (tv[i].c_ov)
                chk($sformatf("v%0d_out_valid", i),
                    int'(out_valid), int'(tv[i].e_ov));
            if (tv[i].c_dc) begin
                chk($sformatf("v%0d_out_data", i),
                    int'(out_data), int'(tv[i].e_data));
                chk($sformatf("v%0d_out_chan", i),
                    int'(out_chan), int'(tv[i].e_chan));
            end
            @(posedge clk);
            #1;
        end

        m_known = 0; m_valid = 0; m_data = 0; m_chan = 0; m_ptr = N - 1;
        rnd_cycle(1, 1, 0, 4'hF, 1, 32'h11223344);
        rnd_cycle(1, 1, 0, 4'hF, 1, 32'h11223344);
        rm = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) rm = ~rm;
            rv = 4'($urandom);
            if ($urandom_range(3) == 0) rv = 4'hF;
            rnd_cycle(($urandom_range(199) == 0), rm,
                      int'($urandom_range(3)), rv,
                      ($urandom_range(3) != 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
